// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between three requesters
// (0 = instruction fetch, 1 = data access, 2 = debug/loader). It runs one
// transaction at a time and hides a 0..3 cycle RAM read latency.
// Every output comes straight from a register.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1   // legal range 0..3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req_i,
  input  logic [2:0]          we_i,
  input  logic [3*ADDR_W-1:0] addr_i,
  input  logic [3*DATA_W-1:0] wdata_i,
  output logic [2:0]          gnt_o,
  output logic [2:0]          done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                busy_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  input  logic [DATA_W-1:0]   data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Count loaded on entry to WAIT; the read data is captured when it reaches 1
  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY);

  state_t            state_reg;
  logic [1:0]        rr_last_reg;
  logic [1:0]        winner_reg;
  logic              is_write_reg;
  logic [1:0]        wait_cnt_reg;
  logic [2:0]        gnt_reg;
  logic [2:0]        done_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              busy_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  logic [ADDR_W-1:0] req_addr  [3];
  logic [DATA_W-1:0] req_wdata [3];

  logic [1:0] pick;
  logic       pick_valid;
  logic [1:0] cand;

  // Split the flat request buses into one address/data word per requester
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slice
      assign req_addr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign req_wdata[gi] = wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Requester reached after stepping (offset+1) places past base, modulo 3
  function automatic logic [1:0] rr_next(input logic [1:0] base, input int offset);
    int idx;
    idx = (int'(base) + offset + 1) % 3;
    return 2'(idx);
  endfunction

  // Round-robin pick: scan from the requester after the last winner; the
  // downward loop lets the closest candidate overwrite farther ones
  always_comb begin
    pick       = 2'd0;
    pick_valid = 1'b0;
    cand       = 2'd0;
    for (int j = 2; j >= 0; j--) begin
      cand = rr_next(rr_last_reg, j);
      if (req_i[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Transaction sequencer: grant, issue, wait out the read latency, respond
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_last_reg  <= 2'd2;
      winner_reg   <= 2'd0;
      is_write_reg <= 1'b0;
      wait_cnt_reg <= 2'd0;
      gnt_reg      <= 3'b000;
      done_reg     <= 3'b000;
      rdata_reg    <= '0;
      busy_reg     <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
    end else begin
      // Grant, done and write enable are single-cycle pulses by default
      gnt_reg  <= 3'b000;
      done_reg <= 3'b000;
      we_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg    <= ISSUE;
            gnt_reg      <= 3'b001 << pick;
            rr_last_reg  <= pick;
            winner_reg   <= pick;
            is_write_reg <= we_i[pick];
            we_reg       <= we_i[pick];
            addr_reg     <= req_addr[pick];
            data_reg     <= req_wdata[pick];
            busy_reg     <= 1'b1;
          end
        end
        ISSUE: begin
          if (is_write_reg) begin
            state_reg <= RESP;
            done_reg  <= 3'b001 << winner_reg;
          end else if (RD_LATENCY == 0) begin
            // Combinational RAM: data for addr_o is already on data_i
            rdata_reg <= data_i;
            state_reg <= RESP;
            done_reg  <= 3'b001 << winner_reg;
          end else begin
            wait_cnt_reg <= LAT_INIT;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 2'd1) begin
            rdata_reg <= data_i;
            state_reg <= RESP;
            done_reg  <= 3'b001 << winner_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o   = gnt_reg;
  assign done_o  = done_reg;
  assign rdata_o = rdata_reg;
  assign busy_o  = busy_reg;
  assign we_o    = we_reg;
  assign addr_o  = addr_reg;
  assign data_o  = data_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified RAM (we/addr/data_o/data_i) between three requesters: 0 = instruction fetch, 1 = data memory access, 2 = debug/program loader.
- Serialises requests into RAM transactions using round-robin arbitration.
- Handles a configurable RAM read latency and returns read data plus a per-requester completion pulse.
- Sits between the control/fetch/memory-access stages and the RAM.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LATENCY, 1, RAM read latency in cycles: 0 = combinational read; 1..3 = registered read. Legal range 0..3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_i  in  3  request per requester; bit k = requester k
- we_i  in  3  per-requester write enable: 1 = write, 0 = read
- addr_i  in  3*ADDR_W  per-requester address; requester k uses slice [k*ADDR_W +: ADDR_W]
- wdata_i  in  3*DATA_W  per-requester write data; same slicing as addr_i
- gnt_o  out  3  one-hot pulse: request accepted
- done_o  out  3  one-hot pulse: transaction complete (rdata_o valid for reads)
- rdata_o  out  DATA_W  read data
- busy_o  out  1  high whenever state != IDLE
- we_o  out  1  RAM write enable
- addr_o  out  ADDR_W  RAM address
- data_o  out  DATA_W  RAM write data
- data_i  in  DATA_W  RAM read data

Behaviour:
- Reset (async, any state): state = IDLE; rr_last = 2, so requester 0 has first priority. All outputs are 0: we_o, addr_o, data_o, gnt_o, done_o, rdata_o, busy_o. Any in-flight transaction is discarded and no done_o is issued for it.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If req_i != 0, select the winner: the first requester with req high, scanning from rr_last+1 mod 3 upward.
  - At the clock edge, latch the winner's we/addr/wdata into addr_o, data_o and we_o; set gnt_o[winner] = 1 and rr_last = winner; go to ISSUE.
  - If req_i == 0, stay in IDLE.
- ISSUE (cycle t):
  - addr_o and data_o are valid; we_o = latched we; gnt_o is one-hot for this single cycle only.
  - Write: go to RESP.
  - Read with RD_LATENCY = 0: capture data_i into rdata_o at the end of t; go to RESP.
  - Read with RD_LATENCY > 0: go to WAIT with wait counter = RD_LATENCY.
- WAIT:
  - we_o = 0; addr_o is held.
  - The counter decrements each cycle.
  - When the counter reaches 1, capture data_i into rdata_o (the sample is taken at the end of cycle t+RD_LATENCY); go to RESP.
- RESP:
  - done_o[winner] = 1 for exactly one cycle; go to IDLE.
  - Read data is valid in rdata_o while done_o is high and holds until the next read capture.
- we_o is high only during the ISSUE cycle of a write, and never in any other state.
- addr_o and data_o hold their last values outside ISSUE/WAIT; they are not forced to 0.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt_o[k] is seen.
  - Sampling happens at the IDLE→ISSUE edge, so later changes do not affect the transaction in flight.
  - req_i[k] still high in the IDLE cycle after RESP counts as a new request.
- Throughput: at most one outstanding transaction; no pipelining.
  - Write: 3 cycles (IDLE, ISSUE, RESP).
  - Read: 3 + RD_LATENCY cycles.
- Fairness: with all three requesting continuously, the grant order is 0,1,2,0,1,2...
  - A requester that drops req before being granted loses no position: the pointer moves only on grant.
- req_i == 0 in IDLE: no outputs change except the gnt_o/done_o pulses returning to 0.

Test Plan:
- Reset values: assert reset mid-clock (asynchronous) -> all outputs 0 immediately, busy_o = 0.
- Single read, RD_LATENCY = 1: req_i = 3'b001, addr = 0x40, RAM returns 0xDEADBEEF in cycle t+1 -> gnt_o = 001 at t, done_o = 001 at t+2, rdata_o = 0xDEADBEEF, we_o never 1.
- Write from requester 1: addr = 0x80, wdata = 0x12345678 -> we_o = 1 for exactly one cycle with addr_o = 0x80, data_o = 0x12345678; done_o = 010 the next cycle.
- Round-robin: all req bits held high, writes -> gnt_o sequence 001, 010, 100, 001, each gnt 3 cycles apart; no two gnt/done bits are ever high together.
- Reset mid-WAIT: RD_LATENCY = 3, read issued, reset asserted in the first WAIT cycle -> no done_o; after release, rr_last = 2, so requester 0 wins when all request.
- Latency 0: RD_LATENCY = 0, combinational RAM -> done_o two cycles after the IDLE sample; rdata_o equals RAM[addr].
